// File: rtl/traffic_light_ped_ctrl_pkg.sv
// Shared light-state encoding for the sequencer and the LED decoder.
// Both sides import this package so the 2-bit code has a single definition.
package traffic_light_ped_ctrl_pkg;

   typedef logic [1:0] light_state_t;

   localparam light_state_t RED     = 2'd0;
   localparam light_state_t YELLOW1 = 2'd1;
   localparam light_state_t GREEN   = 2'd2;
   localparam light_state_t YELLOW2 = 2'd3;

   // The cycle RED -> YELLOW1 -> GREEN -> YELLOW2 -> RED is a plain 2-bit increment.
   function automatic light_state_t next_light(input light_state_t s);
      return light_state_t'(s + 2'd1);
   endfunction

endpackage

// File: rtl/traffic_light_ped_ctrl_tick_gen.sv
// Prescaler producing a registered one-cycle tick every TICK_DIV clocks.
// The tick is high in the cycle after the counter reads TICK_DIV-1.
module traffic_light_ped_ctrl_tick_gen #(
   parameter int TICK_DIV = 50000000
) (
   input  logic clk,
   input  logic res,
   output logic tick
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments and an async reset branch.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= (cnt == LAST);
         cnt  <= (cnt == LAST) ? '0 : cnt + PW'(1);
      end
   end

endmodule

// File: rtl/traffic_light_ped_ctrl.sv
// Timed traffic-light sequencer with a pedestrian request that can cut GREEN
// short once the minimum green time has elapsed.
module traffic_light_ped_ctrl
   import traffic_light_ped_ctrl_pkg::*;
#(
   parameter int TICK_DIV        = 50000000,
   parameter int RED_TICKS       = 5,
   parameter int YELLOW_TICKS    = 2,
   parameter int GREEN_TICKS     = 6,
   parameter int MIN_GREEN_TICKS = 2
) (
   input  logic         clk_50MHz,
   input  logic         res,
   input  logic         ped_btn,
   output light_state_t out_state,
   output logic         out_ped_wait,
   output logic         out_tick
);

   localparam int MAX_DUR = (RED_TICKS > YELLOW_TICKS)
                            ? ((RED_TICKS > GREEN_TICKS) ? RED_TICKS : GREEN_TICKS)
                            : ((YELLOW_TICKS > GREEN_TICKS) ? YELLOW_TICKS : GREEN_TICKS);
   localparam int TW = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

   localparam logic [TW-1:0] RED_LAST    = TW'(RED_TICKS - 1);
   localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_TICKS - 1);
   localparam logic [TW-1:0] GREEN_LAST  = TW'(GREEN_TICKS - 1);
   localparam logic [TW-1:0] MIN_LAST    = TW'(MIN_GREEN_TICKS - 1);

   logic         tick;
   light_state_t state_q, state_n;
   logic [TW-1:0] timer_q, timer_n, dur_last;
   logic         ped_s1, ped_s2, ped_s3;
   logic         ped_edge, pending_q, early_exit, enter_red;

   traffic_light_ped_ctrl_tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick_gen (
      .clk (clk_50MHz),
      .res (res),
      .tick(tick)
   );

   // Two flops resynchronize the button; the third remembers the last level for edge detect.
   always_ff @(posedge clk_50MHz or posedge res) begin
      if (res) begin
         ped_s1 <= 1'b0;
         ped_s2 <= 1'b0;
         ped_s3 <= 1'b0;
      end else begin
         ped_s1 <= ped_btn;
         ped_s2 <= ped_s1;
         ped_s3 <= ped_s2;
      end
   end

   assign ped_edge = ped_s2 & ~ped_s3;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      dur_last   = RED_LAST;
      state_n    = state_q;
      timer_n    = timer_q;
      early_exit = 1'b0;
      case (state_q)
         RED:     dur_last = RED_LAST;
         GREEN:   dur_last = GREEN_LAST;
         default: dur_last = YELLOW_LAST;
      endcase
      early_exit = (state_q == GREEN) && pending_q && (timer_q >= MIN_LAST);
      if (tick) begin
         if ((timer_q == dur_last) || early_exit) begin
            state_n = next_light(state_q);
            timer_n = '0;
         end else begin
            timer_n = timer_q + TW'(1);
         end
      end
   end

   assign enter_red = (state_n == RED) && (state_q != RED);

   always_ff @(posedge clk_50MHz or posedge res) begin
      if (res) begin
         state_q   <= RED;
         timer_q   <= '0;
         pending_q <= 1'b0;
      end else begin
         state_q <= state_n;
         timer_q <= timer_n;
         // Serving the request on RED entry takes priority over a new edge in the same cycle.
         if (enter_red)
            pending_q <= 1'b0;
         else if (ped_edge && (state_q != RED))
            pending_q <= 1'b1;
      end
   end

   assign out_state    = state_q;
   assign out_ped_wait = pending_q;
   assign out_tick     = tick;

endmodule

// File: tb/tb_traffic_light_ped_ctrl.sv
// Directed bench for traffic_light_ped_ctrl with TICK_DIV=4, RED=3, YELLOW=1, GREEN=4, MIN_GREEN=2.
// Cycle n means the interval after the n-th rising edge following reset release.
module tb_traffic_light_ped_ctrl;

   logic       clk_50MHz = 1'b0;
   logic       res       = 1'b1;
   logic       ped_btn   = 1'b0;
   logic [1:0] out_state;
   logic       out_ped_wait;
   logic       out_tick;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk_50MHz = ~clk_50MHz;

   traffic_light_ped_ctrl #(
      .TICK_DIV       (4),
      .RED_TICKS      (3),
      .YELLOW_TICKS   (1),
      .GREEN_TICKS    (4),
      .MIN_GREEN_TICKS(2)
   ) dut (
      .clk_50MHz   (clk_50MHz),
      .res         (res),
      .ped_btn     (ped_btn),
      .out_state   (out_state),
      .out_ped_wait(out_ped_wait),
      .out_tick    (out_tick)
   );

   // Undisturbed 36-cycle schedule: RED 12, YELLOW1 4, GREEN 16, YELLOW2 4.
   function automatic logic [1:0] exp_state(input int c);
      int p;
      if (c < 1) return 2'd0;
      p = (c - 1) % 36;
      if (p < 12) return 2'd0;
      if (p < 16) return 2'd1;
      if (p < 32) return 2'd2;
      return 2'd3;
   endfunction

   task automatic adv();
      @(posedge clk_50MHz);
      cyc++;
      @(negedge clk_50MHz);
   endtask

   task automatic goto_cyc(input int n);
      while (cyc < n) adv();
   endtask

   task automatic do_reset();
      @(negedge clk_50MHz);
      res     = 1'b1;
      ped_btn = 1'b0;
      repeat (2) @(posedge clk_50MHz);
      @(negedge clk_50MHz);
      res = 1'b0;
      cyc = 0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk_50MHz);
      @(negedge clk_50MHz);
      total++;
      if (out_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", out_state); end
      total++;
      if (out_ped_wait !== 1'b0) begin bad++; $display("FAIL rst_wait got=%b exp=0", out_ped_wait); end
      total++;
      if (out_tick !== 1'b0) begin bad++; $display("FAIL rst_tick got=%b exp=0", out_tick); end
      res = 1'b0;
      cyc = 0;
      goto_cyc(4);
      total++;
      if (out_tick !== 1'b1) begin bad++; $display("FAIL first_tick got=%b exp=1", out_tick); end
      res = 1'b1;
      #1;
      total++;
      if (out_tick !== 1'b0) begin bad++; $display("FAIL async_rst_tick got=%b exp=0", out_tick); end
   endtask

   task automatic test_free_run();
      do_reset();
      for (int c = 1; c <= 80; c++) begin
         goto_cyc(c);
         total++;
         if (out_state !== exp_state(c)) begin
            bad++; $display("FAIL run_state cyc=%0d got=%0d exp=%0d", c, out_state, exp_state(c));
         end
         total++;
         if (out_tick !== 1'((c % 4) == 0)) begin
            bad++; $display("FAIL run_tick cyc=%0d got=%b exp=%b", c, out_tick, (c % 4) == 0);
         end
         total++;
         if (out_ped_wait !== 1'b0) begin
            bad++; $display("FAIL run_wait cyc=%0d got=%b exp=0", c, out_ped_wait);
         end
      end
   endtask

   task automatic test_early_exit();
      logic [1:0] es;
      do_reset();
      goto_cyc(17);
      ped_btn = 1'b1;
      goto_cyc(18);
      ped_btn = 1'b0;
      // GREEN is cut from 16 to 8 cycles, so the rest of the schedule is 8 cycles ahead.
      for (int c = 18; c <= 60; c++) begin
         goto_cyc(c);
         es = (c < 25) ? exp_state(c) : exp_state(c + 8);
         total++;
         if (out_state !== es) begin
            bad++; $display("FAIL early_state cyc=%0d got=%0d exp=%0d", c, out_state, es);
         end
         total++;
         if (out_ped_wait !== 1'(c >= 20 && c < 29)) begin
            bad++; $display("FAIL early_wait cyc=%0d got=%b exp=%b", c, out_ped_wait, c >= 20 && c < 29);
         end
      end
   endtask

   task automatic test_held_button();
      logic [1:0] es;
      do_reset();
      goto_cyc(25);
      ped_btn = 1'b1;
      // Raised at timer=2, GREEN ends at the tick in cycle 28: schedule shifts by 4 cycles.
      for (int c = 26; c <= 80; c++) begin
         goto_cyc(c);
         if (c == 75) ped_btn = 1'b0;
         es = (c < 29) ? exp_state(c) : exp_state(c + 4);
         total++;
         if (out_state !== es) begin
            bad++; $display("FAIL held_state cyc=%0d got=%0d exp=%0d", c, out_state, es);
         end
         total++;
         if (out_ped_wait !== 1'(c >= 28 && c < 33)) begin
            bad++; $display("FAIL held_wait cyc=%0d got=%b exp=%b", c, out_ped_wait, c >= 28 && c < 33);
         end
      end
   endtask

   task automatic test_red_ignored();
      do_reset();
      goto_cyc(5);
      ped_btn = 1'b1;
      goto_cyc(6);
      ped_btn = 1'b0;
      for (int c = 6; c <= 40; c++) begin
         goto_cyc(c);
         total++;
         if (out_state !== exp_state(c)) begin
            bad++; $display("FAIL red_state cyc=%0d got=%0d exp=%0d", c, out_state, exp_state(c));
         end
         total++;
         if (out_ped_wait !== 1'b0) begin
            bad++; $display("FAIL red_wait cyc=%0d got=%b exp=0", c, out_ped_wait);
         end
      end
   endtask

   task automatic test_reset_mid_green();
      do_reset();
      goto_cyc(17);
      ped_btn = 1'b1;
      goto_cyc(18);
      ped_btn = 1'b0;
      goto_cyc(20);
      total++;
      if (out_tick !== 1'b1 || out_ped_wait !== 1'b1 || out_state !== 2'd2) begin
         bad++; $display("FAIL pre_rst tick=%b wait=%b state=%0d exp 1 1 2", out_tick, out_ped_wait, out_state);
      end
      res = 1'b1;
      #1;
      total++;
      if (out_state !== 2'd0) begin bad++; $display("FAIL mid_rst_state got=%0d exp=0", out_state); end
      total++;
      if (out_ped_wait !== 1'b0) begin bad++; $display("FAIL mid_rst_wait got=%b exp=0", out_ped_wait); end
      total++;
      if (out_tick !== 1'b0) begin bad++; $display("FAIL mid_rst_tick got=%b exp=0", out_tick); end
      @(posedge clk_50MHz);
      @(negedge clk_50MHz);
      res = 1'b0;
      cyc = 0;
      for (int c = 1; c <= 40; c++) begin
         goto_cyc(c);
         total++;
         if (out_state !== exp_state(c) || out_tick !== 1'((c % 4) == 0)) begin
            bad++; $display("FAIL restart cyc=%0d state=%0d tick=%b exp %0d %b",
                            c, out_state, out_tick, exp_state(c), (c % 4) == 0);
         end
      end
   endtask

   task automatic test_clear_wins();
      // Control: an edge one cycle earlier is latched, then served on RED entry.
      do_reset();
      goto_cyc(33);
      ped_btn = 1'b1;
      goto_cyc(34);
      ped_btn = 1'b0;
      goto_cyc(36);
      total++;
      if (out_ped_wait !== 1'b1) begin bad++; $display("FAIL ctl_wait36 got=%b exp=1", out_ped_wait); end
      goto_cyc(37);
      total++;
      if (out_ped_wait !== 1'b0) begin bad++; $display("FAIL ctl_wait37 got=%b exp=0", out_ped_wait); end
      // Edge detected in the YELLOW2 expiry tick cycle: clear and set collide.
      do_reset();
      goto_cyc(34);
      ped_btn = 1'b1;
      goto_cyc(35);
      ped_btn = 1'b0;
      goto_cyc(36);
      total++;
      if (out_state !== 2'd3 || out_ped_wait !== 1'b0) begin
         bad++; $display("FAIL cw36 state=%0d wait=%b exp 3 0", out_state, out_ped_wait);
      end
      for (int c = 37; c <= 40; c++) begin
         goto_cyc(c);
         total++;
         if (out_state !== 2'd0 || out_ped_wait !== 1'b0) begin
            bad++; $display("FAIL clear_wins cyc=%0d state=%0d wait=%b exp 0 0", c, out_state, out_ped_wait);
         end
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_early_exit();
      test_held_button();
      test_red_ignored();
      test_reset_mid_green();
      test_clear_wins();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
